// File: rtl/rgs_bus_master_pkg.sv
// Shared constants, state encoding and response-assembly helpers for rgs_bus_master.
// Optional build macro: RGS_BUS_MASTER_STAT_CHECK_EN adds the queue-status states.
package rgs_bus_master_pkg;

    localparam logic [1:0] OP_TIME_RD = 2'd0;
    localparam logic [1:0] OP_RXQ_POP = 2'd1;
    localparam logic [1:0] OP_TXQ_POP = 2'd2;
    localparam logic [1:0] OP_CTRL_WR = 2'd3;

    localparam logic [7:0] A_CTRL     = 8'h00;
    localparam logic [7:0] A_RXQ_STAT = 8'h04;
    localparam logic [7:0] A_TXQ_STAT = 8'h08;
    localparam logic [7:0] A_TIME0    = 8'h40;
    localparam logic [7:0] A_RXQ0     = 8'h50;
    localparam logic [7:0] A_TXQ0     = 8'h58;

    localparam int BIT_TIME_RD = 0;
    localparam int BIT_TXQ_RD  = 8;
    localparam int BIT_RXQ_RD  = 10;
    localparam logic [31:0] ENGINE_MASK = 32'h0000_0501;

    localparam int RSP_W       = 96;
    localparam int RSP_NS_LSB  = 0;
    localparam int RSP_SEC_LSB = 38;
    localparam int RSP_QLO_LSB = 0;
    localparam int RSP_QHI_LSB = 32;

    typedef enum logic [3:0] {
        S_IDLE, S_WLO, S_WHI, S_SETTLE, S_PREQ, S_PCHK, S_RD, S_RDL, S_CLR, S_RSP
`ifdef RGS_BUS_MASTER_STAT_CHECK_EN
        , S_SREQ, S_SCHK, S_SEMPTY
`endif
    } state_t;

    function automatic logic [31:0] op_mask(input logic [1:0] op);
        logic [31:0] m;
        m = 32'h0000_0000;
        case (op)
            OP_TIME_RD: m[BIT_TIME_RD] = 1'b1;
            OP_RXQ_POP: m[BIT_RXQ_RD]  = 1'b1;
            OP_TXQ_POP: m[BIT_TXQ_RD]  = 1'b1;
            default:    m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] rd_base(input logic [1:0] op);
        case (op)
            OP_TIME_RD: return A_TIME0;
            OP_RXQ_POP: return A_RXQ0;
            default:    return A_TXQ0;
        endcase
    endfunction

    function automatic logic [1:0] rd_last(input logic [1:0] op);
        return (op == OP_TIME_RD) ? 2'd3 : 2'd1;
    endfunction

    // Merge one read word into the response at the position its index implies.
    function automatic logic [RSP_W-1:0] rsp_put(input logic [1:0] op, input logic [1:0] idx,
                                                 input logic [31:0] w, input logic [RSP_W-1:0] cur);
        logic [RSP_W-1:0] r;
        r = cur;
        if (op == OP_TIME_RD) begin
            case (idx)
                2'd0:    r[RSP_SEC_LSB+47 -: 16] = w[15:0];
                2'd1:    r[RSP_SEC_LSB+31 -: 32] = w;
                2'd2:    r[RSP_NS_LSB+37 -: 30]  = w[29:0];
                default: r[RSP_NS_LSB+7 -: 8]    = w[7:0];
            endcase
        end else if (idx == 2'd0) begin
            r[RSP_QHI_LSB+31 -: 32] = w;
        end else begin
            r[RSP_QLO_LSB+31 -: 32] = w;
        end
        return r;
    endfunction

endpackage

// File: rtl/rgs_bus_master_poll_timer.sv
// Settle down-counter after the rising control write, and the poll attempt counter
// whose last-attempt flag drives the timeout decision.
module rgs_bus_master_poll_timer #(
    parameter int SETTLE_CYC = 4,
    parameter int POLL_MAX   = 255,
    parameter int POLL_W     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic settle_load,
    input  logic settle_en,
    input  logic poll_clr,
    input  logic poll_inc,
    output logic settle_done,
    output logic poll_last
);
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0]  SET_LOAD  = SET_W'(SETTLE_CYC - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(POLL_MAX - 1);

    logic [SET_W-1:0]  settle_cnt;
    logic [POLL_W-1:0] poll_cnt;

    // Settle counter: loaded during WHI so it reaches zero on the last settle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (settle_load) begin
            settle_cnt <= SET_LOAD;
        end else if (settle_en && (settle_cnt != '0)) begin
            settle_cnt <= settle_cnt - SET_W'(1);
        end else begin
            settle_cnt <= settle_cnt;
        end
    end

    // Poll attempt counter, restarted for every command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt <= '0;
        end else if (poll_clr) begin
            poll_cnt <= '0;
        end else if (poll_inc) begin
            poll_cnt <= poll_cnt + POLL_W'(1);
        end else begin
            poll_cnt <= poll_cnt;
        end
    end

    assign settle_done = (settle_cnt == '0);
    assign poll_last   = (poll_cnt == POLL_LAST);

endmodule

// File: rtl/rgs_bus_master.sv
// Register-bus initiator running the time-snapshot and timestamp-queue handshakes.
// Optional build macro: RGS_BUS_MASTER_STAT_CHECK_EN (queue-status check before pops).
module rgs_bus_master
    import rgs_bus_master_pkg::*;
#(
    parameter int SETTLE_CYC = 4,
    parameter int POLL_MAX   = 255,
    parameter int POLL_W     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid_in,
    output logic        cmd_ready_out,
    input  logic [1:0]  cmd_op_in,
    input  logic [31:0] cmd_wdata_in,
    output logic        rsp_valid_out,
    input  logic        rsp_ready_in,
    output logic        rsp_err_out,
    output logic [95:0] rsp_data_out,
    output logic        wr_out,
    output logic        rd_out,
    output logic [7:0]  addr_out,
    output logic [31:0] data_out,
    input  logic [31:0] data_in
);
    state_t      state;
    logic [1:0]  op;
    logic [31:0] ctrl_sh;
    logic [1:0]  rd_idx;
    logic        err;
    logic        hit;
    logic        settle_done;
    logic        poll_last;

    assign hit = |(data_in & op_mask(op));

    rgs_bus_master_poll_timer #(
        .SETTLE_CYC (SETTLE_CYC),
        .POLL_MAX   (POLL_MAX),
        .POLL_W     (POLL_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .settle_load (state == S_WHI),
        .settle_en   (state == S_SETTLE),
        .poll_clr    (state == S_IDLE),
        .poll_inc    ((state == S_PCHK) && !hit && !poll_last),
        .settle_done (settle_done),
        .poll_last   (poll_last)
    );

    // Command FSM; bus and response outputs are registered alongside each transition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            op            <= OP_TIME_RD;
            ctrl_sh       <= 32'h0000_0000;
            rd_idx        <= 2'd0;
            err           <= 1'b0;
            cmd_ready_out <= 1'b1;
            rsp_valid_out <= 1'b0;
            rsp_err_out   <= 1'b0;
            rsp_data_out  <= 96'h0;
            wr_out        <= 1'b0;
            rd_out        <= 1'b0;
            addr_out      <= 8'h00;
            data_out      <= 32'h0000_0000;
        end else begin
            wr_out   <= 1'b0;
            rd_out   <= 1'b0;
            addr_out <= A_CTRL;
            data_out <= 32'h0000_0000;
            case (state)
                S_IDLE: begin
                    if (cmd_valid_in && cmd_ready_out) begin
                        op            <= cmd_op_in;
                        cmd_ready_out <= 1'b0;
                        err           <= 1'b0;
                        rsp_data_out  <= 96'h0;
                        if (cmd_op_in == OP_CTRL_WR) begin
                            ctrl_sh  <= cmd_wdata_in & ~ENGINE_MASK;
                            wr_out   <= 1'b1;
                            data_out <= cmd_wdata_in;
                            state    <= S_WLO;
                        end
`ifdef RGS_BUS_MASTER_STAT_CHECK_EN
                        else if (cmd_op_in != OP_TIME_RD) begin
                            rd_out   <= 1'b1;
                            addr_out <= (cmd_op_in == OP_RXQ_POP) ? A_RXQ_STAT : A_TXQ_STAT;
                            state    <= S_SREQ;
                        end
`endif
                        else begin
                            // Low write first so the following high write is a true rising edge.
                            wr_out   <= 1'b1;
                            data_out <= ctrl_sh;
                            state    <= S_WLO;
                        end
                    end
                end
                S_WLO: begin
                    if (op == OP_CTRL_WR) begin
                        rsp_valid_out <= 1'b1;
                        state         <= S_RSP;
                    end else begin
                        wr_out   <= 1'b1;
                        data_out <= ctrl_sh | op_mask(op);
                        state    <= S_WHI;
                    end
                end
                S_WHI: state <= S_SETTLE;
                S_SETTLE: begin
                    if (settle_done) begin
                        rd_out <= 1'b1;
                        state  <= S_PREQ;
                    end
                end
                S_PREQ: state <= S_PCHK;
                S_PCHK: begin
                    if (hit) begin
                        rd_out   <= 1'b1;
                        addr_out <= rd_base(op);
                        rd_idx   <= 2'd0;
                        state    <= S_RD;
                    end else if (poll_last) begin
                        err      <= 1'b1;
                        wr_out   <= 1'b1;
                        data_out <= ctrl_sh;
                        state    <= S_CLR;
                    end else begin
                        rd_out <= 1'b1;
                        state  <= S_PREQ;
                    end
                end
                S_RD: begin
                    // data_in belongs to the read issued in the previous cycle.
                    if (rd_idx != 2'd0) begin
                        rsp_data_out <= rsp_put(op, rd_idx - 2'd1, data_in, rsp_data_out);
                    end
                    if (rd_idx == rd_last(op)) begin
                        state <= S_RDL;
                    end else begin
                        rd_out   <= 1'b1;
                        addr_out <= rd_base(op) + {4'h0, rd_idx + 2'd1, 2'b00};
                        rd_idx   <= rd_idx + 2'd1;
                    end
                end
                S_RDL: begin
                    rsp_data_out <= rsp_put(op, rd_idx, data_in, rsp_data_out);
                    wr_out       <= 1'b1;
                    data_out     <= ctrl_sh;
                    state        <= S_CLR;
                end
                S_CLR: begin
                    rsp_valid_out <= 1'b1;
                    rsp_err_out   <= err;
                    state         <= S_RSP;
                end
                S_RSP: begin
                    if (rsp_ready_in) begin
                        rsp_valid_out <= 1'b0;
                        rsp_err_out   <= 1'b0;
                        rsp_data_out  <= 96'h0;
                        cmd_ready_out <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
`ifdef RGS_BUS_MASTER_STAT_CHECK_EN
                S_SREQ: state <= S_SCHK;
                S_SCHK: begin
                    if (data_in[7:0] == 8'h00) begin
                        err   <= 1'b1;
                        state <= S_SEMPTY;
                    end else begin
                        wr_out   <= 1'b1;
                        data_out <= ctrl_sh;
                        state    <= S_WLO;
                    end
                end
                S_SEMPTY: begin
                    rsp_valid_out <= 1'b1;
                    rsp_err_out   <= 1'b1;
                    state         <= S_RSP;
                end
`endif
                default: begin
                    rsp_valid_out <= 1'b0;
                    rsp_err_out   <= 1'b0;
                    cmd_ready_out <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rgs_bus_master.sv
// Scoreboard bench for rgs_bus_master with a behavioural register-block responder.
`timescale 1ns/1ps
module tb_rgs_bus_master;

`ifdef RGS_BUS_MASTER_STAT_CHECK_EN
    localparam int SX = 2;
`else
    localparam int SX = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid_in = 1'b0;
    logic        cmd_ready_out;
    logic [1:0]  cmd_op_in = 2'd0;
    logic [31:0] cmd_wdata_in = 32'h0;
    logic        rsp_valid_out;
    logic        rsp_ready_in = 1'b1;
    logic        rsp_err_out;
    logic [95:0] rsp_data_out;
    logic        wr_out;
    logic        rd_out;
    logic [7:0]  addr_out;
    logic [31:0] data_out;
    logic [31:0] data_in = 32'h0;

    always #5 clk = ~clk;

    rgs_bus_master #(.SETTLE_CYC(4), .POLL_MAX(4), .POLL_W(8)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
        .cmd_op_in(cmd_op_in), .cmd_wdata_in(cmd_wdata_in),
        .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
        .rsp_err_out(rsp_err_out), .rsp_data_out(rsp_data_out),
        .wr_out(wr_out), .rd_out(rd_out), .addr_out(addr_out),
        .data_out(data_out), .data_in(data_in)
    );

    // Responder model: ready bit for hit_bit appears after fail_polls misses (-1 = never).
    logic [31:0] mem [0:63];
    int          fail_polls = 0;
    int          hit_bit = 0;
    logic [31:0] stat_val = 32'h0000_0003;
    int          poll_n = 0;

    always @(posedge clk) begin
        if (wr_out && addr_out == 8'h00) poll_n <= 0;
        if (rd_out) begin
            if (addr_out == 8'h00) begin
                data_in <= (fail_polls >= 0 && poll_n >= fail_polls) ? (32'd1 << hit_bit)
                                                                    : (32'h0000_0501 & ~(32'd1 << hit_bit));
                poll_n  <= poll_n + 1;
            end else if (addr_out == 8'h04 || addr_out == 8'h08) begin
                data_in <= stat_val;
            end else begin
                data_in <= mem[addr_out[7:2]];
            end
        end else begin
            data_in <= 32'hFFFF_FFFF;
        end
    end

    typedef struct {
        logic        err;
        logic [95:0] data;
        int          lat;
        int          polls;
    } exp_t;

    exp_t        exp_q[$];
    logic [39:0] exp_wr[$];
    logic [39:0] wlog[$];
    int          cyc = 0;
    int          polls = 0;
    bit          both = 1'b0;
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (wr_out) wlog.push_back({addr_out, data_out});
        if (rd_out && addr_out == 8'h00) polls++;
        if (wr_out && rd_out) both = 1'b1;
    endtask

    task automatic expect_rsp(input logic err, input logic [95:0] data, input int lat, input int pl);
        exp_t e;
        e.err = err; e.data = data; e.lat = lat; e.polls = pl;
        exp_q.push_back(e);
    endtask

    task automatic expect_wr(input logic [31:0] d);
        exp_wr.push_back({8'h00, d});
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [31:0] wd, input int hold);
        int          acc;
        int          t;
        exp_t        e;
        logic [39:0] w;
        wlog.delete();
        polls = 0;
        both = 1'b0;
        rsp_ready_in = (hold == 0);
        cmd_valid_in = 1'b1;
        cmd_op_in = op;
        cmd_wdata_in = wd;
        t = 0;
        while (!cmd_ready_out && t < 50) begin tick(); t++; end
        acc = cyc;
        tick();
        cmd_valid_in = 1'b0;
        cmd_wdata_in = 32'h0;
        t = 0;
        while (!rsp_valid_out && t < 300) begin tick(); t++; end
        e = exp_q.pop_front();
        chk("rsp_seen", rsp_valid_out, 1'b1);
        chk("rsp_latency", cyc - acc, e.lat);
        chk("rsp_err", rsp_err_out, e.err);
        chk("rsp_data", rsp_data_out, e.data);
        if (hold > 0) begin
            repeat (hold) tick();
            chk("rsp_hold_valid", rsp_valid_out, 1'b1);
            chk("rsp_hold_data", rsp_data_out, e.data);
            rsp_ready_in = 1'b1;
        end
        tick();
        chk("rsp_release", {rsp_valid_out, cmd_ready_out}, 2'b01);
        chk("poll_reads", polls, e.polls);
        chk("wr_rd_overlap", both, 1'b0);
        chk("wr_count", wlog.size(), exp_wr.size());
        while (exp_wr.size() > 0) begin
            w = exp_wr.pop_front();
            if (wlog.size() > 0) chk("wr_trace", wlog.pop_front(), w);
        end
    endtask

    initial begin
        int t;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        repeat (3) tick();
        chk("rst_ready", cmd_ready_out, 1'b1);
        chk("rst_strobes", {wr_out, rd_out, rsp_valid_out, rsp_err_out}, 4'b0000);
        chk("rst_bus", {addr_out, data_out}, 40'h0);
        chk("rst_rsp_data", rsp_data_out, 96'h0);
        rst = 1'b0;
        tick();

        // TIME_RD, first poll succeeds.
        hit_bit = 0; fail_polls = 0;
        mem[16] = 32'h0000_ABCD; mem[17] = 32'h1234_5678; mem[18] = 32'h3FFF_FFFF; mem[19] = 32'h0000_00AA;
        expect_rsp(1'b0, {10'd0, 48'hABCD_1234_5678, 30'h3FFF_FFFF, 8'hAA}, 15, 1);
        expect_wr(32'h0); expect_wr(32'h1); expect_wr(32'h0);
        run_cmd(2'd0, 32'h0, 0);

        // RXQ_POP, three failed polls, response held for three cycles.
        hit_bit = 10; fail_polls = 3;
        mem[20] = 32'hDEAD_BEEF; mem[21] = 32'h0102_0304;
        expect_rsp(1'b0, {32'd0, 64'hDEAD_BEEF_0102_0304}, 19 + SX, 4);
        expect_wr(32'h0); expect_wr(32'h400); expect_wr(32'h0);
        run_cmd(2'd1, 32'h0, 3);

        // TXQ_POP timeout after POLL_MAX=4 polls.
        hit_bit = 8; fail_polls = -1;
        expect_rsp(1'b1, 96'h0, 16 + SX, 4);
        expect_wr(32'h0); expect_wr(32'h100); expect_wr(32'h0);
        run_cmd(2'd2, 32'h0, 0);

        // CTRL_WR writes the raw word and loads the masked shadow.
        expect_rsp(1'b0, 96'h0, 2, 0);
        expect_wr(32'h0000_0FFF);
        run_cmd(2'd3, 32'h0000_0FFF, 0);

        // TIME_RD on top of the shadow, one failed poll, upper word bits must be dropped.
        hit_bit = 0; fail_polls = 1;
        mem[16] = 32'hFFFF_1111; mem[17] = 32'h2222_3333; mem[18] = 32'hC444_4444; mem[19] = 32'hFFFF_FF55;
        expect_rsp(1'b0, {10'd0, 48'h1111_2222_3333, 30'h0444_4444, 8'h55}, 17, 2);
        expect_wr(32'h0000_0AFE); expect_wr(32'h0000_0AFF); expect_wr(32'h0000_0AFE);
        run_cmd(2'd0, 32'h0, 0);

        // Reset during the RD phase of TIME_RD.
        hit_bit = 0; fail_polls = 0;
        cmd_valid_in = 1'b1; cmd_op_in = 2'd0;
        tick();
        cmd_valid_in = 1'b0;
        t = 0;
        while (!(rd_out && addr_out == 8'h44) && t < 50) begin tick(); t++; end
        chk("rd_phase_reached", {rd_out, addr_out}, {1'b1, 8'h44});
        rst = 1'b1;
        tick();
        chk("midop_rst_outputs", {wr_out, rd_out, cmd_ready_out, rsp_valid_out}, 4'b0010);
        rst = 1'b0;
        tick();

        // RXQ_POP after the reset starts from a cleared shadow.
        hit_bit = 10; fail_polls = 0;
        mem[20] = 32'hCAFE_F00D; mem[21] = 32'h0BAD_C0DE;
        expect_rsp(1'b0, {32'd0, 64'hCAFE_F00D_0BAD_C0DE}, 13 + SX, 1);
        expect_wr(32'h0); expect_wr(32'h400); expect_wr(32'h0);
        run_cmd(2'd1, 32'h0, 0);

`ifdef RGS_BUS_MASTER_STAT_CHECK_EN
        // Empty RX queue: error response with no control writes.
        stat_val = 32'h0000_0000;
        expect_rsp(1'b1, 96'h0, 4, 0);
        run_cmd(2'd1, 32'h0, 0);
        stat_val = 32'h0000_0003;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
